// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: single-button LED mode selector.
// A raw active-low push-button is synchronized and debounced. Each accepted
// press steps the mode OFF -> ON -> SLOW -> FAST -> BREATHE -> OFF.
// The LED drive for the current mode is generated from a registered datapath.
module led_mode_ctrl #(
   parameter int DB_CYCLES    = 500000,
   parameter int SLOW_HALF    = 25000000,
   parameter int FAST_HALF    = 5000000,
   parameter int PWM_BITS     = 8,
   parameter int BREATHE_STEP = 100000
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       sw_i,
   output logic       led_o,
   output logic [2:0] mode_o,
   output logic       press_o
);

   localparam int DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int BLK_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
   localparam int STEP_W   = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;

   localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [BLK_W-1:0]    SLOW_LAST = BLK_W'(SLOW_HALF - 1);
   localparam logic [BLK_W-1:0]    FAST_LAST = BLK_W'(FAST_HALF - 1);
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(BREATHE_STEP - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [PWM_BITS-1:0] DUTY_MAXM = DUTY_MAX - PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

   typedef enum logic [2:0] {
      M_OFF     = 3'd0,
      M_ON      = 3'd1,
      M_SLOW    = 3'd2,
      M_FAST    = 3'd3,
      M_BREATHE = 3'd4
   } mode_t;

   // synchronizer / debounce state
   logic                sw_m_q, sw_s_q;
   logic                sw_db_q, sw_db_d;
   logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
   logic                press_q, press_d;

   // mode state
   mode_t               mode_q;
   logic                chg_q;

   // LED datapath state
   logic                led_q, led_d;
   logic [BLK_W-1:0]    blk_q, blk_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                up_q, up_d;
   logic [BLK_W-1:0]    blk_last;

   // Two-flop synchronizer; idles high so reset never looks like a press.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         sw_m_q <= 1'b1;
         sw_s_q <= 1'b1;
      end else begin
         sw_m_q <= sw_i;
         sw_s_q <= sw_m_q;
      end
   end

   // Debounce: accept a new level only after DB_CYCLES consecutive differing cycles.
   always_comb begin
      sw_db_d  = sw_db_q;
      db_cnt_d = '0;
      if (sw_s_q != sw_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            sw_db_d = sw_s_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
      // press is the accepted 1->0 transition only; release is ignored
      press_d = sw_db_q & ~sw_db_d;
   end

   // Register debounced level, its counter and the press pulse.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         sw_db_q  <= 1'b1;
         db_cnt_q <= '0;
         press_q  <= 1'b0;
      end else begin
         sw_db_q  <= sw_db_d;
         db_cnt_q <= db_cnt_d;
         press_q  <= press_d;
      end
   end

   // Mode FSM: step once per press pulse; illegal codes fall back to OFF.
   // chg_q flags the first cycle in a new mode so the datapath can restart.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         mode_q <= M_OFF;
         chg_q  <= 1'b0;
      end else begin
         chg_q <= 1'b0;
         case (mode_q)
            M_OFF:     if (press_q) begin mode_q <= M_ON;      chg_q <= 1'b1; end
            M_ON:      if (press_q) begin mode_q <= M_SLOW;    chg_q <= 1'b1; end
            M_SLOW:    if (press_q) begin mode_q <= M_FAST;    chg_q <= 1'b1; end
            M_FAST:    if (press_q) begin mode_q <= M_BREATHE; chg_q <= 1'b1; end
            M_BREATHE: if (press_q) begin mode_q <= M_OFF;     chg_q <= 1'b1; end
            default: begin
               mode_q <= M_OFF;
               chg_q  <= 1'b1;
            end
         endcase
      end
   end

   assign blk_last = (mode_q == M_SLOW) ? SLOW_LAST : FAST_LAST;

   // LED datapath: entry value on a mode change, otherwise per-mode behaviour.
   // Idle modes keep every counter parked at zero.
   always_comb begin
      led_d  = 1'b0;
      blk_d  = '0;
      step_d = '0;
      pwm_d  = '0;
      duty_d = '0;
      up_d   = 1'b1;
      if (chg_q) begin
         led_d = (mode_q == M_ON) || (mode_q == M_SLOW) || (mode_q == M_FAST);
      end else begin
         case (mode_q)
            M_ON: led_d = 1'b1;
            M_SLOW, M_FAST: begin
               led_d = led_q;
               if (blk_q == blk_last) begin
                  led_d = ~led_q;
               end else begin
                  blk_d = blk_q + BLK_W'(1);
               end
            end
            M_BREATHE: begin
               pwm_d  = pwm_q + PWM_BITS'(1);
               led_d  = (pwm_q < duty_q);
               duty_d = duty_q;
               up_d   = up_q;
               step_d = step_q + STEP_W'(1);
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  if (up_q) begin
                     if (duty_q == DUTY_MAX) begin
                        duty_d = DUTY_MAXM;
                        up_d   = 1'b0;
                     end else begin
                        duty_d = duty_q + PWM_BITS'(1);
                        if (duty_q == DUTY_MAXM) up_d = 1'b0;
                     end
                  end else begin
                     if (duty_q == '0) begin
                        duty_d = DUTY_ONE;
                        up_d   = 1'b1;
                     end else begin
                        duty_d = duty_q - PWM_BITS'(1);
                        if (duty_q == DUTY_ONE) up_d = 1'b1;
                     end
                  end
               end
            end
            default: led_d = 1'b0;
         endcase
      end
   end

   // Register the LED datapath.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         led_q  <= 1'b0;
         blk_q  <= '0;
         step_q <= '0;
         pwm_q  <= '0;
         duty_q <= '0;
         up_q   <= 1'b1;
      end else begin
         led_q  <= led_d;
         blk_q  <= blk_d;
         step_q <= step_d;
         pwm_q  <= pwm_d;
         duty_q <= duty_d;
         up_q   <= up_d;
      end
   end

   assign led_o   = led_q;
   assign mode_o  = mode_q;
   assign press_o = press_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: presses push expected {mode, entry led} into a
// scoreboard; a monitor pops one entry per press_o pulse and checks it.
module tb_led_mode_ctrl;

   logic       sysclk = 1'b0;
   logic       rst    = 1'b1;
   logic       sw_i   = 1'b1;
   logic       led_o;
   logic [2:0] mode_o;
   logic       press_o;

   always #5 sysclk = ~sysclk;

   led_mode_ctrl #(
      .DB_CYCLES(4), .SLOW_HALF(8), .FAST_HALF(2), .PWM_BITS(3), .BREATHE_STEP(2)
   ) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .sw_i   (sw_i),
      .led_o  (led_o),
      .mode_o (mode_o),
      .press_o(press_o)
   );

   typedef struct {
      logic [2:0] mode;
      logic       led;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every press pulse must match a queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge sysclk);
         if (press_o === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_press: got press_o=1 expected no pulse (mode %0d)", mode_o);
            end else begin
               e = sb.pop_front();
               @(negedge sysclk);
               chk("press_width", press_o, 0);
               chk("mode_after_press", mode_o, e.mode);
               @(negedge sysclk);
               chk("led_entry", led_o, e.led);
            end
         end
      end
   end

   task automatic press(input int low, input logic [2:0] m, input logic l);
      exp_t e;
      e.mode = m;
      e.led  = l;
      sb.push_back(e);
      sw_i = 1'b0;
      repeat (low) @(negedge sysclk);
      sw_i = 1'b1;
      repeat (10) @(negedge sysclk);
   endtask

   task automatic wait_mode(input logic [2:0] m, input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge sysclk);
         if (mode_o == m) break;
      end
      chk(name, mode_o, m);
   endtask

   // Length of the current run of led_o==v, starting at the current sample.
   task automatic run_len(input logic v, output int n);
      n = 0;
      while (led_o === v && n < 100) begin
         n++;
         @(negedge sysclk);
      end
   endtask

   initial begin
      int         n;
      logic       v;
      logic [0:32] pat;
      // k0 = entry, duty ramps 0..7..0 every 2 cycles against an 8-cycle PWM
      pat = 33'b000000000_1111111_0_1111_0000_11_000000;

      rst  = 1'b1;
      sw_i = 1'b1;
      repeat (5) @(negedge sysclk);
      rst = 1'b0;
      chk("rst_led", led_o, 0);
      chk("rst_mode", mode_o, 0);
      chk("rst_press", press_o, 0);
      for (int i = 0; i < 5; i++) begin
         repeat (10) @(negedge sysclk);
         chk("idle_led", led_o, 0);
         chk("idle_mode", mode_o, 0);
         chk("idle_press", press_o, 0);
      end

      // short glitches must be filtered
      repeat (3) begin
         sw_i = 1'b0;
         repeat (2) @(negedge sysclk);
         sw_i = 1'b1;
         repeat (6) @(negedge sysclk);
      end
      chk("glitch_mode", mode_o, 0);
      chk("glitch_led", led_o, 0);

      // long hold: one pulse, ON
      press(20, 3'd1, 1'b1);
      chk("on_mode", mode_o, 1);
      chk("on_led", led_o, 1);

      // SLOW: half-period 8
      press(8, 3'd2, 1'b1);
      v = led_o;
      run_len(v, n);
      run_len(~v, n);
      chk("slow_half_a", n, 8);
      run_len(v, n);
      chk("slow_half_b", n, 8);

      // FAST: half-period 2
      press(8, 3'd3, 1'b1);
      v = led_o;
      run_len(v, n);
      run_len(~v, n);
      chk("fast_half_a", n, 2);
      run_len(v, n);
      chk("fast_half_b", n, 2);

      // BREATHE: cycle-exact LED pattern from entry
      fork
         press(8, 3'd4, 1'b0);
      join_none
      wait_mode(3'd4, "breathe_mode");
      for (int k = 0; k <= 32; k++) begin
         @(negedge sysclk);
         chk($sformatf("breathe_led_k%0d", k), led_o, pat[k]);
      end

      // back to OFF
      press(8, 3'd0, 1'b0);
      chk("off_mode", mode_o, 0);
      chk("off_led", led_o, 0);

      // walk to FAST, then reset mid-count
      press(8, 3'd1, 1'b1);
      press(8, 3'd2, 1'b1);
      press(8, 3'd3, 1'b1);
      repeat (3) @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);
      rst = 1'b0;
      chk("midrst_mode", mode_o, 0);
      chk("midrst_led", led_o, 0);
      chk("midrst_press", press_o, 0);

      press(8, 3'd1, 1'b1);
      chk("restart_mode", mode_o, 1);

      repeat (20) @(negedge sysclk);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
